// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding, error codes and default header bytes for the frame receiver.
package uart_frame_pkg;
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_DONE} state_t;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;
endpackage

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: 16-bit event counter that sticks at all-ones instead of wrapping.
module uart_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses HDR0 HDR1 CMD LEN payload CHK frames from the UART byte stream into a payload RAM.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF,
  parameter int MAX_LEN = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  output logic              rx_data_ready,
  input  logic              rx_frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       err_cnt
);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, len_q, len_d, sum_q, sum_d, idx_q, idx_d;
  logic [7:0] wr_data_q, wr_data_d, frame_cmd_q, frame_cmd_d, frame_len_q, frame_len_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0] err_code_q, err_code_d;
  logic ready_q, ready_d, wr_en_q, wr_en_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic xfer, ok_inc, err_inc;
  assign xfer = rx_data_valid && ready_q;
  assign busy = state_q != S_HDR0;
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    len_d = len_q;
    sum_d = sum_q;
    idx_d = idx_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    frame_done_d = 1'b0;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    frame_err_d = 1'b0;
    err_code_d = err_code_q;
    ok_inc = 1'b0;
    err_inc = 1'b0;
    // a line-idle abort overrides any byte arriving in the same cycle
    if (rx_frame_ack && busy) begin
      state_d = S_HDR0;
      frame_err_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
      err_inc = 1'b1;
    end else if (state_q == S_DONE) begin
      state_d = S_HDR0;
    end else if (xfer) begin
      case (state_q)
        S_HDR0: state_d = (rx_data == HDR0) ? S_HDR1 : S_HDR0;
        S_HDR1: state_d = (rx_data == HDR1) ? S_CMD : (rx_data == HDR0) ? S_HDR1 : S_HDR0;
        S_CMD: begin
          cmd_d = rx_data;
          sum_d = rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = rx_data;
          sum_d = sum_q + rx_data;
          idx_d = '0;
          state_d = (rx_data > MAX_LEN_B) ? S_HDR0 : (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
          frame_err_d = rx_data > MAX_LEN_B;
          err_code_d = (rx_data > MAX_LEN_B) ? ERR_LEN : err_code_q;
          err_inc = rx_data > MAX_LEN_B;
        end
        S_PAYLOAD: begin
          wr_en_d = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = rx_data;
          sum_d = sum_q + rx_data;
          idx_d = idx_q + 8'd1;
          state_d = (idx_q + 8'd1 == len_q) ? S_CHK : S_PAYLOAD;
        end
        S_CHK: begin
          frame_done_d = rx_data == sum_q;
          frame_cmd_d = (rx_data == sum_q) ? cmd_q : frame_cmd_q;
          frame_len_d = (rx_data == sum_q) ? len_q : frame_len_q;
          ok_inc = rx_data == sum_q;
          frame_err_d = rx_data != sum_q;
          err_code_d = (rx_data != sum_q) ? ERR_CHK : err_code_q;
          err_inc = rx_data != sum_q;
          state_d = S_DONE;
        end
        default: state_d = S_HDR0;
      endcase
    end
    ready_d = state_d != S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_HDR0;
      cmd_q <= '0;
      len_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      frame_done_q <= 1'b0;
      frame_cmd_q <= '0;
      frame_len_q <= '0;
      frame_err_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      len_q <= len_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      frame_err_q <= frame_err_d;
      err_code_q <= err_code_d;
    end
  assign rx_data_ready = ready_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_cmd = frame_cmd_q;
  assign frame_len = frame_len_q;
  assign frame_err = frame_err_q;
  assign err_code = err_code_q;
  uart_sat_cnt u_ok_cnt (.clk(clk), .rst_n(rst_n), .inc(ok_inc), .cnt(ok_cnt));
  uart_sat_cnt u_err_cnt (.clk(clk), .rst_n(rst_n), .inc(err_inc), .cnt(err_cnt));
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frame checks against a frame-level expectation model.
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_data_valid = 1'b0, rx_frame_ack = 1'b0;
  logic rx_data_ready, wr_en, frame_done, frame_err, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, frame_cmd, frame_len;
  logic [1:0] err_code;
  logic [15:0] ok_cnt, err_cnt;
  int total = 0, bad = 0, exp_ok = 0, exp_err = 0;
  logic [7:0] pay [256];
  logic [15:0] wr_log [$];
  logic [15:0] done_log [$];
  logic [1:0] err_log [$];

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .rx_frame_ack(rx_frame_ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .frame_cmd(frame_cmd),
    .frame_len(frame_len), .frame_err(frame_err), .err_code(err_code), .busy(busy),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({2'b00, wr_addr, wr_data});
    if (frame_done) done_log.push_back({frame_cmd, frame_len});
    if (frame_err) err_log.push_back(err_code);
  end

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    err_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    int t = 0;
    idle(gap);
    rx_data = b;
    rx_data_valid = 1'b1;
    while (!rx_data_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      bad++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input bit bad_chk, input int max_gap);
    logic [7:0] sum;
    sum = cmd + 8'(len);
    send_byte(8'h55, $urandom_range(0, max_gap));
    send_byte(8'hAA, $urandom_range(0, max_gap));
    send_byte(cmd, $urandom_range(0, max_gap));
    send_byte(8'(len), $urandom_range(0, max_gap));
    if (len <= 64) begin
      for (int i = 0; i < len; i++) begin
        send_byte(pay[i], $urandom_range(0, max_gap));
        sum = sum + pay[i];
      end
      send_byte(bad_chk ? sum + 8'h01 : sum, $urandom_range(0, max_gap));
    end
  endtask

  task automatic test_reset();
    idle(2);
    total++;
    if ({rx_data_ready, wr_en, wr_addr, wr_data, frame_done, frame_cmd, frame_len, frame_err, err_code, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0", {rx_data_ready, wr_en, wr_addr, wr_data, frame_done, frame_cmd, frame_len, frame_err, err_code, busy});
    end
    total++;
    if ({ok_cnt, err_cnt} !== 32'h0) begin bad++; $display("FAIL reset_counters got=%0h exp=0", {ok_cnt, err_cnt}); end
    rst_n = 1'b1;
    idle(2);
    total++;
    if (rx_data_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%0b exp=1", rx_data_ready); end
  endtask

  task automatic test_basic();
    clear_logs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd0, 8'h10}) begin bad++; $display("FAIL basic_wr_latency got=%0h exp=%0h", {wr_en, wr_addr, wr_data}, {1'b1, 6'd0, 8'h10}); end
    send_byte(8'h20); send_byte(8'h30); send_byte(8'h64);
    exp_ok = sat_inc(exp_ok);
    total++;
    if ({frame_done, frame_cmd, frame_len, rx_data_ready} !== {1'b1, 8'h01, 8'h03, 1'b0}) begin
      bad++; $display("FAIL basic_done got=%0h exp=%0h", {frame_done, frame_cmd, frame_len, rx_data_ready}, {1'b1, 8'h01, 8'h03, 1'b0});
    end
    total++;
    if (ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL basic_ok_cnt got=%0h exp=%0h", ok_cnt, exp_ok); end
    idle(1);
    total++;
    if ({rx_data_ready, busy} !== 2'b10) begin bad++; $display("FAIL basic_after_done got=%0b exp=10", {rx_data_ready, busy}); end
    total++;
    if (wr_log.size() != 3 || wr_log[0] !== 16'h0010 || wr_log[1] !== 16'h0120 || wr_log[2] !== 16'h0230) begin
      bad++; $display("FAIL basic_writes got=%p exp=0010 0120 0230", wr_log);
    end
    total++;
    if (done_log.size() != 1 || err_log.size() != 0) begin bad++; $display("FAIL basic_pulses got=%0d/%0d exp=1/0", done_log.size(), err_log.size()); end
  endtask

  task automatic test_zero_len();
    clear_logs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    exp_ok = sat_inc(exp_ok);
    idle(2);
    total++;
    if (wr_log.size() != 0 || done_log.size() != 1 || done_log[0] !== 16'h0200) begin
      bad++; $display("FAIL zero_len got=w%0d d%p exp=w0 d0200", wr_log.size(), done_log);
    end
    total++;
    if (ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL zero_len_ok_cnt got=%0h exp=%0h", ok_cnt, exp_ok); end
  endtask

  task automatic test_len_err();
    clear_logs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h41);
    exp_err = sat_inc(exp_err);
    total++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin bad++; $display("FAIL len_err got=%0h exp=%0h", {frame_err, err_code, busy}, {1'b1, 2'd1, 1'b0}); end
    total++;
    if (err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL len_err_cnt got=%0h exp=%0h", err_cnt, exp_err); end
    pay[0] = 8'hC3;
    send_frame(8'h09, 1, 1'b0, 0);
    exp_ok = sat_inc(exp_ok);
    idle(2);
    total++;
    if (done_log.size() != 1 || done_log[0] !== 16'h0901 || wr_log.size() != 1 || wr_log[0] !== 16'h00C3) begin
      bad++; $display("FAIL len_err_recover got=%p/%p exp=0901/00c3", done_log, wr_log);
    end
  endtask

  task automatic test_chk_err();
    clear_logs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
    exp_err = sat_inc(exp_err);
    total++;
    if ({frame_err, err_code, frame_done} !== {1'b1, 2'd2, 1'b0}) begin bad++; $display("FAIL chk_err got=%0h exp=%0h", {frame_err, err_code, frame_done}, {1'b1, 2'd2, 1'b0}); end
    idle(2);
    total++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h00FF) begin bad++; $display("FAIL chk_err_ram got=%p exp=00ff", wr_log); end
    total++;
    if ({frame_cmd, frame_len} !== 16'h0901) begin bad++; $display("FAIL chk_err_held got=%0h exp=0901", {frame_cmd, frame_len}); end
    total++;
    if (err_cnt !== 16'(exp_err) || ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL chk_err_cnts got=%0h/%0h exp=%0h/%0h", ok_cnt, err_cnt, exp_ok, exp_err); end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h07);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy got=%0b exp=1", busy); end
    rx_frame_ack = 1'b1;
    @(negedge clk);
    rx_frame_ack = 1'b0;
    exp_err = sat_inc(exp_err);
    total++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd3, 1'b0}) begin bad++; $display("FAIL timeout got=%0h exp=%0h", {frame_err, err_code, busy}, {1'b1, 2'd3, 1'b0}); end
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h07);
    rx_data = 8'h55;
    rx_data_valid = 1'b1;
    rx_frame_ack = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_frame_ack = 1'b0;
    exp_err = sat_inc(exp_err);
    idle(1);
    total++;
    if (busy !== 1'b0 || err_log.size() != 2 || err_log[1] !== 2'd3) begin bad++; $display("FAIL timeout_coincident got=b%0b n%0d exp=b0 n2", busy, err_log.size()); end
    rx_frame_ack = 1'b1;
    @(negedge clk);
    rx_frame_ack = 1'b0;
    idle(1);
    total++;
    if (err_log.size() != 2 || err_cnt !== 16'(exp_err) || busy !== 1'b0) begin bad++; $display("FAIL idle_ack got=n%0d c%0h exp=n2 c%0h", err_log.size(), err_cnt, exp_err); end
  endtask

  task automatic test_resync();
    clear_logs();
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    exp_ok = sat_inc(exp_ok);
    idle(2);
    total++;
    if (done_log.size() != 1 || done_log[0] !== 16'h0500 || err_log.size() != 0) begin bad++; $display("FAIL resync got=%p exp=0500", done_log); end
    total++;
    if (ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL resync_ok_cnt got=%0h exp=%0h", ok_cnt, exp_ok); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      logic [7:0] cmd;
      int len;
      bit bad_chk;
      cmd = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65, 255)) : int'($urandom_range(0, 64));
      bad_chk = $urandom_range(0, 3) == 0;
      for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
      clear_logs();
      send_frame(cmd, len, bad_chk, (k % 2) * 2);
      idle(2);
      if (len > 64) begin
        exp_err = sat_inc(exp_err);
        total++;
        if (err_log.size() != 1 || err_log[0] !== 2'd1 || done_log.size() != 0 || wr_log.size() != 0) begin
          bad++; $display("FAIL rand_len k=%0d got=e%p d%0d w%0d exp=e1", k, err_log, done_log.size(), wr_log.size());
        end
      end else begin
        total++;
        if (wr_log.size() != len) begin
          bad++; $display("FAIL rand_wr_count k=%0d got=%0d exp=%0d", k, wr_log.size(), len);
        end else begin
          for (int i = 0; i < len; i++) begin
            total++;
            if (wr_log[i] !== {2'b00, 6'(i), pay[i]}) begin bad++; $display("FAIL rand_wr k=%0d i=%0d got=%0h exp=%0h", k, i, wr_log[i], {2'b00, 6'(i), pay[i]}); end
          end
        end
        if (bad_chk) begin
          exp_err = sat_inc(exp_err);
          total++;
          if (err_log.size() != 1 || err_log[0] !== 2'd2 || done_log.size() != 0) begin bad++; $display("FAIL rand_chk k=%0d got=e%p d%0d exp=e2", k, err_log, done_log.size()); end
        end else begin
          exp_ok = sat_inc(exp_ok);
          total++;
          if (done_log.size() != 1 || done_log[0] !== {cmd, 8'(len)} || err_log.size() != 0) begin bad++; $display("FAIL rand_done k=%0d got=%p exp=%0h", k, done_log, {cmd, 8'(len)}); end
        end
      end
      total++;
      if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL rand_cnts k=%0d got=%0h/%0h exp=%0h/%0h", k, ok_cnt, err_cnt, exp_ok, exp_err); end
    end
  endtask

  task automatic test_saturation();
    clear_logs();
    force dut.u_err_cnt.cnt_q = 16'hFFFF;
    idle(1);
    release dut.u_err_cnt.cnt_q;
    exp_err = 65535;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h41);
    exp_err = sat_inc(exp_err);
    idle(2);
    total++;
    if (err_log.size() != 1 || err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL sat_err_cnt got=%0h n%0d exp=%0h n1", err_cnt, err_log.size(), exp_err); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03); send_byte(8'h10);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, wr_en, rx_data_ready, frame_cmd, frame_len, ok_cnt, err_cnt} !== '0) begin
      bad++; $display("FAIL reset_mid got=%0h exp=0", {busy, wr_en, rx_data_ready, frame_cmd, frame_len, ok_cnt, err_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ok = 0;
    exp_err = 0;
    clear_logs();
    idle(2);
    total++;
    if (done_log.size() != 0 || err_log.size() != 0 || wr_log.size() != 0) begin bad++; $display("FAIL reset_mid_pulses got=%0d/%0d/%0d exp=0/0/0", done_log.size(), err_log.size(), wr_log.size()); end
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
    send_frame(8'h01, 3, 1'b0, 0);
    exp_ok = sat_inc(exp_ok);
    idle(2);
    total++;
    if (done_log.size() != 1 || done_log[0] !== 16'h0103 || ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL reset_mid_recover got=%p c%0h exp=0103 c%0h", done_log, ok_cnt, exp_ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_len_err();
    test_chk_err();
    test_timeout();
    test_resync();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
